// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: request FIFO, credit-based issue to a fixed-latency fpu, result FIFO.
// Optional macro FPU_SEQ_FLAGS_EN stores {nan,inf,zero,subnormal} per result entry.
module fpu_op_sequencer #(
    parameter int IN_DEPTH    = 4,
    parameter int RES_DEPTH   = 4,
    parameter int TAG_W       = 4,
    parameter int FPU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [1:0]       in_opcode,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [1:0]       fpu_opcode,
    input  logic [31:0]      fpu_o,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic [3:0]       res_flags
);
    localparam int L   = FPU_LATENCY;
    localparam int IPW = $clog2(IN_DEPTH);
    localparam int RPW = $clog2(RES_DEPTH);
    localparam int FLW = $clog2(FPU_LATENCY + 2);

    localparam logic [IPW-1:0] IP_ONE  = IPW'(1);
    localparam logic [IPW:0]   IC_ONE  = (IPW+1)'(1);
    localparam logic [IPW:0]   IC_FULL = (IPW+1)'(IN_DEPTH);
    localparam logic [RPW-1:0] RP_ONE  = RPW'(1);
    localparam logic [RPW:0]   RC_ONE  = (RPW+1)'(1);
    localparam logic [RPW:0]   RC_FULL = (RPW+1)'(RES_DEPTH);
    localparam logic [FLW-1:0] FL_ONE  = FLW'(1);

    logic [31:0]      ia_q   [IN_DEPTH];
    logic [31:0]      ib_q   [IN_DEPTH];
    logic [1:0]       iop_q  [IN_DEPTH];
    logic [TAG_W-1:0] itag_q [IN_DEPTH];
    logic [IPW-1:0]   iwr_q, iwr_d, ird_q, ird_d;
    logic [IPW:0]     icnt_q, icnt_d;

    logic [31:0]      fa_q, fa_d, fb_q, fb_d;
    logic [1:0]       fop_q, fop_d;

    logic [L:0]       pv_q, pv_d;
    logic [TAG_W-1:0] pt_q [L+1];
    logic [TAG_W-1:0] pt_d [L+1];
    logic [FLW-1:0]   infl_q, infl_d;

    logic [31:0]      rdat_q [RES_DEPTH];
    logic [TAG_W-1:0] rtag_q [RES_DEPTH];
    logic [RPW-1:0]   rwr_q, rwr_d, rrd_q, rrd_d;
    logic [RPW:0]     rcnt_q, rcnt_d;

    logic in_push, issue, credit, res_push, res_pop;

    assign in_ready   = (icnt_q != IC_FULL);
    assign res_valid  = (rcnt_q != '0);
    assign res_data   = res_valid ? rdat_q[rrd_q] : 32'h0;
    assign res_tag    = res_valid ? rtag_q[rrd_q] : '0;
    assign fpu_a      = fa_q;
    assign fpu_b      = fb_q;
    assign fpu_opcode = fop_q;

    // Handshakes, credit check and next-state for pointers, counters, fpu regs and pipe.
    always_comb begin
        in_push  = in_valid && in_ready;
        credit   = (32'(infl_q) + 32'(rcnt_q)) < 32'(RES_DEPTH);
        issue    = (icnt_q != '0) && credit;
        res_push = pv_q[L];
        res_pop  = res_valid && res_ready;

        iwr_d  = in_push ? iwr_q + IP_ONE : iwr_q;
        ird_d  = issue ? ird_q + IP_ONE : ird_q;
        icnt_d = icnt_q;
        if (in_push && !issue)
            icnt_d = icnt_q + IC_ONE;
        else if (!in_push && issue)
            icnt_d = icnt_q - IC_ONE;

        fa_d  = issue ? ia_q[ird_q] : fa_q;
        fb_d  = issue ? ib_q[ird_q] : fb_q;
        fop_d = issue ? iop_q[ird_q] : fop_q;

        pv_d    = {pv_q[L-1:0], issue};
        pt_d[0] = issue ? itag_q[ird_q] : '0;
        for (int i = 1; i <= L; i++)
            pt_d[i] = pt_q[i-1];

        infl_d = infl_q;
        if (issue && !res_push)
            infl_d = infl_q + FL_ONE;
        else if (!issue && res_push)
            infl_d = infl_q - FL_ONE;

        rwr_d  = res_push ? rwr_q + RP_ONE : rwr_q;
        rrd_d  = res_pop ? rrd_q + RP_ONE : rrd_q;
        rcnt_d = rcnt_q;
        if (res_push && !res_pop)
            rcnt_d = rcnt_q + RC_ONE;
        else if (!res_push && res_pop)
            rcnt_d = rcnt_q - RC_ONE;
    end

    // Control state: pointers, counts, fpu operand regs and the valid/tag pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iwr_q  <= '0;
            ird_q  <= '0;
            icnt_q <= '0;
            fa_q   <= '0;
            fb_q   <= '0;
            fop_q  <= 2'b00;
            pv_q   <= '0;
            for (int i = 0; i <= L; i++)
                pt_q[i] <= '0;
            infl_q <= '0;
            rwr_q  <= '0;
            rrd_q  <= '0;
            rcnt_q <= '0;
        end else begin
            iwr_q  <= iwr_d;
            ird_q  <= ird_d;
            icnt_q <= icnt_d;
            fa_q   <= fa_d;
            fb_q   <= fb_d;
            fop_q  <= fop_d;
            pv_q   <= pv_d;
            for (int i = 0; i <= L; i++)
                pt_q[i] <= pt_d[i];
            infl_q <= infl_d;
            rwr_q  <= rwr_d;
            rrd_q  <= rrd_d;
            rcnt_q <= rcnt_d;
        end
    end

    // Request storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (in_push) begin
            ia_q[iwr_q]   <= in_a;
            ib_q[iwr_q]   <= in_b;
            iop_q[iwr_q]  <= in_opcode;
            itag_q[iwr_q] <= in_tag;
        end
    end

    // Result storage: capture fpu_o and its tag when the tail stage is valid.
    always_ff @(posedge clk) begin
        if (res_push) begin
            rdat_q[rwr_q] <= fpu_o;
            rtag_q[rwr_q] <= pt_q[L];
        end
    end

`ifdef FPU_SEQ_FLAGS_EN
    logic [3:0] rfl_q [RES_DEPTH];

    function automatic logic [3:0] flags_of(input logic [31:0] w);
        logic e_ff, e_z, m_z;
        e_ff = (w[30:23] == 8'hFF);
        e_z  = (w[30:23] == 8'h00);
        m_z  = (w[22:0] == 23'h0);
        return {e_ff && !m_z, e_ff && m_z, e_z && m_z, e_z && !m_z};
    endfunction

    // Classify each result as it is written so the head flags track res_data.
    always_ff @(posedge clk) begin
        if (res_push)
            rfl_q[rwr_q] <= flags_of(fpu_o);
    end

    assign res_flags = res_valid ? rfl_q[rrd_q] : 4'b0000;
`else
    assign res_flags = 4'b0000;
`endif

`ifndef SYNTHESIS
    // Credit makes result overflow impossible; trap it if that ever breaks.
    always @(posedge clk) begin
        if (!rst)
            assert (!(res_push && !res_pop && rcnt_q == RC_FULL));
    end
`endif

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Testbench for fpu_op_sequencer: directed table, multi-cycle sequences, random scoreboard.
// Includes a behavioural 1-cycle fpu model driven by the sequencer's fpu_* outputs.
module tb_fpu_op_sequencer;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a, in_b;
    logic [1:0]       in_opcode;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      fpu_a, fpu_b;
    logic [1:0]       fpu_opcode;
    logic [31:0]      fpu_o = 32'h0;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic [3:0]       res_flags;

    fpu_op_sequencer #(
        .IN_DEPTH(4), .RES_DEPTH(4), .TAG_W(TAG_W), .FPU_LATENCY(1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_tag(in_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_o(fpu_o),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .res_flags(res_flags)
    );

    always #5 clk = ~clk;

`ifdef FPU_SEQ_FLAGS_EN
    localparam logic [3:0] FL_NAN = 4'b1000;
`else
    localparam logic [3:0] FL_NAN = 4'b0000;
`endif

    function automatic real s2r(input logic [31:0] w);
        logic [63:0] d;
        if (w[30:23] == 8'h00)
            d = {w[31], 63'd0};
        else if (w[30:23] == 8'hFF)
            d = {w[31], 11'h7FF, w[22:0], 29'd0};
        else
            d = {w[31], 11'(w[30:23]) + 11'd896, w[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        int se;
        d = $realtobits(r);
        if (d[62:52] == 11'h7FF)
            return (d[51:0] != 0) ? 32'h7FC00000 : {d[63], 8'hFF, 23'd0};
        if (d[62:52] == 11'h000)
            return {d[63], 31'd0};
        se = int'(d[62:52]) - 896;
        if (se >= 255) return {d[63], 8'hFF, 23'd0};
        if (se <= 0) return {d[63], 31'd0};
        return {d[63], se[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        real x, y, r;
        if (a[30:23] == 8'hFF && a[22:0] != 0) return a;
        if (b[30:23] == 8'hFF && b[22:0] != 0) return b;
        x = s2r(a);
        y = s2r(b);
        case (op)
            2'b00:   r = x + y;
            2'b01:   r = x - y;
            2'b10:   r = x / y;
            default: r = x * y;
        endcase
        return r2s(r);
    endfunction

    function automatic logic [3:0] exp_flags(input logic [31:0] w);
`ifdef FPU_SEQ_FLAGS_EN
        if (w[30:23] == 8'hFF) return (w[22:0] != 0) ? 4'b1000 : 4'b0100;
        if (w[30:23] == 8'h00) return (w[22:0] == 0) ? 4'b0010 : 4'b0001;
        return 4'b0000;
`else
        return (w == w) ? 4'b0000 : 4'b1111;
`endif
    endfunction

    // Behavioural fpu: one register stage from operands to O.
    always_ff @(posedge clk) fpu_o <= fpu_fn(fpu_a, fpu_b, fpu_opcode);

    typedef struct packed {
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
    } exp_t;

    typedef struct {
        logic [31:0]      a, b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp_d;
        int               tol;
        logic [3:0]       exp_fl;
    } vec_t;

    int vec_n = 0;
    int fail_n = 0;
    int cyc = 0;
    int acc_n = 0;
    int acc_cyc = 0;
    exp_t exp_q[$];
    logic [TAG_W-1:0] got_tags[$];
    logic [31:0]      got_data[$];
    logic [3:0]       got_fl[$];
    int               got_cyc[$];
    logic             hold_q = 1'b0;
    logic [31:0]      hold_d;
    logic [TAG_W-1:0] hold_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic clear_got();
        got_tags.delete();
        got_data.delete();
        got_fl.delete();
        got_cyc.delete();
    endtask

    // Observe handshakes for the coming edge, update the model, advance one cycle.
    task automatic step();
        exp_t e;
        if (hold_q && res_valid === 1'b1) begin
            check("hold_data", res_data, hold_d);
            check("hold_tag", 32'(res_tag), 32'(hold_t));
        end
        if (in_valid && in_ready) begin
            e.d = fpu_fn(in_a, in_b, in_opcode);
            e.t = in_tag;
            exp_q.push_back(e);
            acc_n++;
            acc_cyc = cyc;
        end
        if (res_valid && res_ready) begin
            got_tags.push_back(res_tag);
            got_data.push_back(res_data);
            got_fl.push_back(res_flags);
            got_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                vec_n++;
                fail_n++;
                $display("FAIL sb_extra: got tag %0h data %h, required no result", res_tag, res_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", res_data, e.d);
                check("sb_tag", 32'(res_tag), 32'(e.t));
                check("sb_flags", 32'(res_flags), 32'(exp_flags(e.d)));
            end
        end
        hold_q = res_valid && !res_ready;
        hold_d = res_data;
        hold_t = res_tag;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_results(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (got_tags.size() < n && k < budget) begin
            step();
            k++;
        end
        if (got_tags.size() < n) begin
            vec_n++;
            fail_n++;
            $display("FAIL %s_timeout: got %0d results, required %0d", name, got_tags.size(), n);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [TAG_W-1:0] t);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_opcode = op;
        in_tag    = t;
    endtask

    vec_t tbl[5];
    int start_acc;
    int tg;
    int diff;

    initial begin
        tbl[0] = '{32'h3F800000, 32'h40000000, 2'b00, 4'd1, 32'h40400000, 0, 4'b0000};
        tbl[1] = '{32'h40400000, 32'h3F800000, 2'b01, 4'd2, 32'h40000000, 0, 4'b0000};
        tbl[2] = '{32'h40000000, 32'h40400000, 2'b11, 4'd3, 32'h40C00000, 0, 4'b0000};
        tbl[3] = '{32'h40800000, 32'h40000000, 2'b10, 4'd4, 32'h40000000, 1, 4'b0000};
        tbl[4] = '{32'h7FC00000, 32'h3F800000, 2'b00, 4'd5, 32'h7FC00000, 0, FL_NAN};

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_opcode = '0;
        in_tag = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_fpu_a", fpu_a, 32'h0);
        check("rst_fpu_b", fpu_b, 32'h0);
        check("rst_fpu_op", 32'(fpu_opcode), 32'd0);
        check("rst_res_data", res_data, 32'h0);
        check("rst_res_tag", 32'(res_tag), 32'd0);
        check("rst_res_flags", 32'(res_flags), 32'd0);
        rst = 1'b0;
        res_ready = 1'b1;
        step();

        // Directed single ops, one at a time: value, tag, flags and 3-edge latency.
        for (int i = 0; i < 5; i++) begin
            clear_got();
            drive(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].tag);
            step();
            in_valid = 1'b0;
            wait_results(1, 12, "tbl");
            if (got_tags.size() > 0) begin
                diff = int'(got_data[0]) - int'(tbl[i].exp_d);
                vec_n++;
                if (diff > tbl[i].tol || diff < -tbl[i].tol) begin
                    fail_n++;
                    $display("FAIL tbl%0d_data: got %h, required %h (tol %0d)",
                             i, got_data[0], tbl[i].exp_d, tbl[i].tol);
                end
                check("tbl_tag", 32'(got_tags[0]), 32'(tbl[i].tag));
                check("tbl_flags", 32'(got_fl[0]), 32'(tbl[i].exp_fl));
                check("tbl_latency", 32'(got_cyc[0] - acc_cyc - 1), 32'd3);
            end
        end
        check("idle_hold_fpu_a", fpu_a, 32'h7FC00000);
        check("idle_hold_fpu_b", fpu_b, 32'h3F800000);

        // Back-to-back SUB/MUL/DIV: tags return on consecutive cycles.
        clear_got();
        for (int i = 1; i <= 3; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].tag);
            step();
        end
        in_valid = 1'b0;
        wait_results(3, 12, "b2b");
        if (got_tags.size() >= 3) begin
            for (int k = 0; k < 3; k++)
                check("b2b_tag", 32'(got_tags[k]), 32'(k + 2));
            check("b2b_gap1", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
            check("b2b_gap2", 32'(got_cyc[2] - got_cyc[1]), 32'd1);
            check("b2b_mul", got_data[1], 32'h40C00000);
        end

        // Backpressure: 4 held in results, 4 queued, in_ready low.
        clear_got();
        res_ready = 1'b0;
        start_acc = acc_n;
        tg = 0;
        for (int k = 0; k < 15; k++) begin
            drive(32'h3F800000 + 32'(tg << 16), 32'h3F800000, 2'b00, TAG_W'(tg));
            step();
            tg = acc_n - start_acc;
        end
        check("bp_accepted", 32'(acc_n - start_acc), 32'd8);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_res_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        while (tg < 10 && cyc < 5000) begin
            drive(32'h3F800000 + 32'(tg << 16), 32'h3F800000, 2'b00, TAG_W'(tg));
            step();
            tg = acc_n - start_acc;
        end
        in_valid = 1'b0;
        wait_results(10, 60, "bp");
        check("bp_count", 32'(got_tags.size()), 32'd10);
        for (int k = 0; k < 10 && k < got_tags.size(); k++)
            check("bp_order", 32'(got_tags[k]), 32'(k));

        // Reset with ops queued and in flight: everything discarded.
        for (int k = 0; k < 5; k++) begin
            drive(32'h40000000, 32'h40000000, 2'b11, TAG_W'(k + 6));
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        hold_q = 1'b0;
        #1;
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        check("mid_rst_res_valid2", 32'(res_valid), 32'd0);
        rst = 1'b0;
        step();
        clear_got();
        drive(32'h40400000, 32'h40000000, 2'b01, 4'hA);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 12; k++)
            step();
        check("post_rst_count", 32'(got_tags.size()), 32'd1);
        if (got_tags.size() > 0) begin
            check("post_rst_tag", 32'(got_tags[0]), 32'hA);
            check("post_rst_data", got_data[0], 32'h3F800000);
        end

        // Random traffic with random backpressure against the queue model.
        for (int k = 0; k < 600; k++) begin
            in_valid  = ($urandom % 4) != 0;
            res_ready = ($urandom % 3) != 0;
            in_a      = {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
            in_b      = {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
            in_opcode = 2'($urandom);
            in_tag    = TAG_W'($urandom);
            step();
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++)
            step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_res_valid", 32'(res_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, fail_n);
        $finish;
    end

endmodule
